// File: rtl/dft_stage_ctrl.sv
// Per-symbol sequencer for the mixed-radix (3^a * 5^b) DFT path.
// Walks the transpose buffer through fill, row pass, write-back and column pass,
// and hands row and column blocks to the shared radix-5 / radix-3 butterfly engine.
// Row and column counts are held in 5-bit registers, so MAX3 and MAX5 must not exceed 31.
module dft_stage_ctrl #(
  parameter int unsigned MAX3 = 27,
  parameter int unsigned MAX5 = 25,
  parameter int unsigned CW   = 10
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] pow3_i,
  input  logic [4:0] pow5_i,
  input  logic       abort_i,
  input  logic       eng_done_i,
  output logic       mem_load_o,
  output logic       mem_adv_o,
  output logic       eng_start_o,
  output logic       eng_sel_o,
  output logic [4:0] eng_len_o,
  output logic       busy_o,
  output logic       sym_done_o,
  output logic       cfg_err_o
);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StP1Go,
    StP1Wait,
    StWb,
    StP2Go,
    StP2Wait,
    StDone
  } state_e;

  localparam logic [7:0] Max3B = 8'(MAX3);
  localparam logic [4:0] Max5B = 5'(MAX5);

  state_e          state_q;
  logic [4:0]      p3_q, p5_q;
  logic [4:0]      blk_q;
  logic [CW-1:0]   cnt_q;
  logic            mem_load_q, mem_adv_q, eng_start_q, eng_sel_q;
  logic [4:0]      eng_len_q;
  logic            busy_q, sym_done_q, cfg_err_q;

  logic [CW-1:0]   n_len;
  logic [CW-1:0]   n_last;
  logic            cfg_ok;

  // Sample count per symbol; both factors are bounded, so the product fits in CW bits.
  assign n_len  = CW'(p3_q) * CW'(p5_q);
  assign n_last = n_len - CW'(1);
  assign cfg_ok = (pow3_i != 8'd0) && (pow3_i <= Max3B) &&
                  (pow5_i != 5'd0) && (pow5_i <= Max5B);

  // Sequencer: state, counters and all registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      p3_q        <= '0;
      p5_q        <= '0;
      blk_q       <= '0;
      cnt_q       <= '0;
      mem_load_q  <= 1'b0;
      mem_adv_q   <= 1'b0;
      eng_start_q <= 1'b0;
      eng_sel_q   <= 1'b0;
      eng_len_q   <= '0;
      busy_q      <= 1'b0;
      sym_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      // Pulse outputs default low; branches raise them for one cycle.
      mem_load_q  <= 1'b0;
      mem_adv_q   <= 1'b0;
      eng_start_q <= 1'b0;
      sym_done_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
      if (abort_i) begin
        state_q   <= StIdle;
        blk_q     <= '0;
        cnt_q     <= '0;
        eng_sel_q <= 1'b0;
        eng_len_q <= '0;
        busy_q    <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (start_i) begin
              if (cfg_ok) begin
                p3_q       <= pow3_i[4:0];
                p5_q       <= pow5_i;
                cnt_q      <= '0;
                blk_q      <= '0;
                mem_load_q <= 1'b1;
                busy_q     <= 1'b1;
                state_q    <= StFill;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          StFill: begin
            if (cnt_q == n_last) begin
              cnt_q       <= '0;
              blk_q       <= '0;
              eng_start_q <= 1'b1;
              eng_sel_q   <= 1'b0;
              eng_len_q   <= p5_q;
              state_q     <= StP1Go;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          StP1Go: state_q <= StP1Wait;
          StP1Wait: begin
            if (eng_done_i) begin
              // The advance pulse after the last row is also the first write-back cycle.
              mem_adv_q <= 1'b1;
              if (blk_q == p3_q - 5'd1) begin
                blk_q   <= '0;
                cnt_q   <= '0;
                state_q <= StWb;
              end else begin
                blk_q       <= blk_q + 5'd1;
                eng_start_q <= 1'b1;
                state_q     <= StP1Go;
              end
            end
          end
          StWb: begin
            if (cnt_q == n_last) begin
              cnt_q       <= '0;
              blk_q       <= '0;
              eng_start_q <= 1'b1;
              eng_sel_q   <= 1'b1;
              eng_len_q   <= p3_q;
              state_q     <= StP2Go;
            end else begin
              cnt_q     <= cnt_q + CW'(1);
              mem_adv_q <= 1'b1;
            end
          end
          StP2Go: state_q <= StP2Wait;
          StP2Wait: begin
            if (eng_done_i) begin
              mem_adv_q <= 1'b1;
              if (blk_q == p5_q - 5'd1) begin
                blk_q      <= '0;
                sym_done_q <= 1'b1;
                state_q    <= StDone;
              end else begin
                blk_q       <= blk_q + 5'd1;
                eng_start_q <= 1'b1;
                state_q     <= StP2Go;
              end
            end
          end
          StDone: begin
            eng_sel_q <= 1'b0;
            eng_len_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= StIdle;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign mem_load_o  = mem_load_q;
  assign mem_adv_o   = mem_adv_q;
  assign eng_start_o = eng_start_q;
  assign eng_sel_o   = eng_sel_q;
  assign eng_len_o   = eng_len_q;
  assign busy_o      = busy_q;
  assign sym_done_o  = sym_done_q;
  assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_dft_stage_ctrl.sv
// Directed bench for dft_stage_ctrl with a fixed-latency engine model.
module tb_dft_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pow3 = 8'd0;
  logic [4:0] pow5 = 5'd0;
  logic       abort = 1'b0;
  logic       eng_done;
  logic       resp_done = 1'b0;
  logic       spur = 1'b0;
  logic       mem_load, mem_adv, eng_start, eng_sel, busy, sym_done, cfg_err;
  logic [4:0] eng_len;
  logic [11:0] outs;

  int n_chk = 0;
  int n_err = 0;

  // Monitor state
  logic clr = 1'b0;
  int cyc, n_load, t_load, t_first, n_row, n_col, bad_len, bad_hold, run, max_run, n_done;
  bit got_first;
  logic last_sel;
  logic [4:0] last_len;
  int exp3, exp5;
  int resp_cnt = 0;

  assign eng_done = resp_done | spur;
  assign outs = {mem_load, mem_adv, eng_start, eng_sel, eng_len, busy, sym_done, cfg_err};

  always #5 clk = ~clk;

  dft_stage_ctrl #(.MAX3(27), .MAX5(25), .CW(10)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .pow3_i      (pow3),
    .pow5_i      (pow5),
    .abort_i     (abort),
    .eng_done_i  (eng_done),
    .mem_load_o  (mem_load),
    .mem_adv_o   (mem_adv),
    .eng_start_o (eng_start),
    .eng_sel_o   (eng_sel),
    .eng_len_o   (eng_len),
    .busy_o      (busy),
    .sym_done_o  (sym_done),
    .cfg_err_o   (cfg_err)
  );

  // Engine model: eng_done pulse 4 cycles after each eng_start.
  always @(negedge clk) begin
    resp_done = 1'b0;
    if (resp_cnt != 0) begin
      resp_cnt = resp_cnt - 1;
      if (resp_cnt == 0) resp_done = 1'b1;
    end
    if (eng_start) resp_cnt = 4;
  end

  // Observe outputs each cycle and accumulate per-symbol statistics.
  always @(negedge clk) begin
    if (clr) begin
      cyc = 0; n_load = 0; t_load = 0; t_first = 0; n_row = 0; n_col = 0;
      bad_len = 0; bad_hold = 0; run = 0; max_run = 0; n_done = 0;
      got_first = 1'b0; last_sel = 1'b0; last_len = 5'd0;
    end else if (!rst) begin
      cyc = cyc + 1;
      if (mem_load) begin
        n_load = n_load + 1;
        t_load = cyc;
        got_first = 1'b0;
      end
      if (eng_start) begin
        if (!got_first) begin
          t_first = cyc;
          got_first = 1'b1;
        end
        if (!eng_sel) begin
          n_row = n_row + 1;
          if (int'(eng_len) != exp5) bad_len = bad_len + 1;
        end else begin
          n_col = n_col + 1;
          if (int'(eng_len) != exp3) bad_len = bad_len + 1;
        end
        last_sel = eng_sel;
        last_len = eng_len;
      end
      if (eng_done && busy && !eng_start && (eng_sel != last_sel || eng_len != last_len))
        bad_hold = bad_hold + 1;
      run = mem_adv ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (sym_done) n_done = n_done + 1;
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon(input int p3, input int p5);
    exp3 = p3;
    exp5 = p5;
    clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic do_start(input int p3, input int p5);
    pow3 = 8'(p3);
    pow5 = 5'(p5);
    start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (sym_done) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_sym_done_seen"}, int'(ok), 1);
  endtask

  task automatic sym_check(input string tag, input int fill, input int rows, input int cols);
    @(negedge clk);
    #1;
    check({tag, "_busy_after"}, int'(busy), 0);
    check({tag, "_loads"}, n_load, 1);
    check({tag, "_fill_len"}, t_first - t_load, fill);
    check({tag, "_rows"}, n_row, rows);
    check({tag, "_cols"}, n_col, cols);
    check({tag, "_len_bad"}, bad_len, 0);
    check({tag, "_hold_bad"}, bad_hold, 0);
    check({tag, "_wb_run"}, max_run, fill);
    check({tag, "_done_cnt"}, n_done, 1);
  endtask

  initial begin
    // Reset
    #3;
    check("reset_outs", int'(outs), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Scenario 1: 3 x 5
    clear_mon(3, 5);
    do_start(3, 5);
    check("s1_mem_load", int'(mem_load), 1);
    check("s1_busy", int'(busy), 1);
    wait_done("s1", 400);
    sym_check("s1", 15, 3, 5);

    // Scenario 2: largest config, N = 675
    clear_mon(27, 25);
    do_start(27, 25);
    wait_done("s2", 3000);
    sym_check("s2", 675, 27, 25);

    // Scenario 3: rejected configs
    clear_mon(0, 0);
    for (int k = 0; k < 3; k++) begin
      int p3v, p5v;
      p3v = (k == 0) ? 0 : (k == 1) ? 3 : 28;
      p5v = (k == 1) ? 26 : 5;
      do_start(p3v, p5v);
      check("s3_cfg_err", int'(cfg_err), 1);
      check("s3_busy", int'(busy), 0);
      check("s3_mem_load", int'(mem_load), 0);
      @(negedge clk);
      #1 check("s3_cfg_err_pulse", int'(cfg_err), 0);
    end
    check("s3_loads", n_load, 0);

    // Scenario 4: ignored start / spurious eng_done
    clear_mon(3, 5);
    do_start(3, 5);
    spur = 1'b1;
    @(negedge clk);
    #1 spur = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (eng_start) break;
    end
    @(negedge clk);
    #1;
    pow3 = 8'd0;
    pow5 = 5'd0;
    start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    check("s4_busy_start_cfg_err", int'(cfg_err), 0);
    wait_done("s4", 400);
    pow3 = 8'd3;
    pow5 = 5'd5;
    start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    check("s4_done_start_load", int'(mem_load), 0);
    check("s4_done_start_busy", int'(busy), 0);
    check("s4_loads", n_load, 1);
    check("s4_rows", n_row, 3);
    check("s4_cols", n_col, 5);
    check("s4_fill_len", t_first - t_load, 15);
    check("s4_done_cnt", n_done, 1);
    check("s4_hold_bad", bad_hold, 0);

    // Scenario 5: abort on write-back cycle 7, then 1 x 5
    clear_mon(3, 5);
    do_start(3, 5);
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(negedge clk);
        #1;
        if (run == 7) begin
          ok = 1'b1;
          break;
        end
      end
      check("s5_wb_reached", int'(ok), 1);
    end
    abort = 1'b1;
    @(negedge clk);
    #1 abort = 1'b0;
    check("s5_abort_outs", int'(outs), 0);
    repeat (6) @(negedge clk);
    clear_mon(1, 5);
    do_start(1, 5);
    wait_done("s5", 400);
    sym_check("s5", 5, 1, 5);

    // Scenario 6: async reset during column pass
    clear_mon(3, 5);
    do_start(3, 5);
    begin
      bit ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        #1;
        if (eng_start && eng_sel) begin
          ok = 1'b1;
          break;
        end
      end
      check("s6_p2_reached", int'(ok), 1);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1 check("s6_rst_outs", int'(outs), 0);
    @(negedge clk);
    #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    clear_mon(3, 5);
    do_start(3, 5);
    check("s6_restart_load", int'(mem_load), 1);
    wait_done("s6", 400);
    sym_check("s6", 15, 3, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dft_stage_ctrl.md
Name: dft_stage_ctrl

Overview:
Per-symbol sequencer for the mixed-radix (3^a·5^b) PUSCH DFT path. It drives the 2-D transpose buffer through four phases: fill, row pass, write-back and column pass. Between transpose steps it hands row and column blocks to the shared radix-5/radix-3 butterfly engine. It sits between the symbol framer (start/config) and the transpose buffer plus engine pair.

Parameters:
MAX3, 27, largest supported row count (3-power factor)
MAX5, 25, largest supported column count (5-power factor)
CW, 10, sample-counter width; must satisfy 2^CW ≥ MAX3·MAX5

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
start  in  1  1-cycle request to process one symbol
pow3  in  8  rows (3-power factor), sampled on accepted start
pow5  in  5  columns (5-power factor), sampled on accepted start
abort  in  1  synchronous abort, returns to IDLE
eng_done  in  1  1-cycle pulse: engine finished current block
mem_load  out  1  1-cycle pulse: buffer begins capture
mem_adv  out  1  buffer advance strobe (pulse or level, per phase)
eng_start  out  1  1-cycle pulse: engine begins block
eng_sel  out  1  0 = radix-5 row pass, 1 = radix-3 column pass
eng_len  out  5  block length handed to engine
busy  out  1  high in every state except IDLE
sym_done  out  1  1-cycle pulse: symbol complete
cfg_err  out  1  1-cycle pulse: start rejected for bad config

Behaviour:
- All outputs are registered. Reset value of every output is 0. State resets to IDLE, and all counters reset to 0.
- N = pow3·pow5 is computed from the latched values at CW bits with no overflow; the worst case is 675.
- IDLE:
  - start with 1≤pow3≤MAX3 and 1≤pow5≤MAX5: latch both values, then next cycle mem_load=1 and go to FILL.
  - start with any other values: cfg_err=1 next cycle, stay in IDLE.
- FILL: the buffer captures one sample per cycle. Counter runs 0..N-1; after exactly N cycles in FILL, go to P1_GO.
- P1_GO: eng_start=1, eng_sel=0, eng_len=pow5 for one cycle, then go to P1_WAIT.
- P1_WAIT: hold until eng_done. On eng_done, next cycle mem_adv=1 for one cycle and row++.
  - If that was row pow3-1, go to WB.
  - Otherwise go to P1_GO.
- WB: mem_adv held high for exactly N consecutive cycles while engine results stream back. Then go to P2_GO.
- P2_GO / P2_WAIT: same as the row pass, but eng_sel=1, eng_len=pow3, and it counts columns 0..pow5-1. After the last column's eng_done, go to DONE.
- DONE: sym_done=1 for one cycle, then go to IDLE. busy drops in the same cycle sym_done drops.
- eng_sel and eng_len hold their values for the whole pass, not only during eng_start.
- Boundary and conflict rules:
  - start while busy: ignored, no cfg_err, latched config unchanged.
  - start in the same cycle as DONE: ignored. start is accepted from the next IDLE cycle.
  - eng_done outside a WAIT state, or coincident with eng_start: ignored.
  - pow3=1 or pow5=1: each pass degenerates to a single block; the sequence is otherwise unchanged.
  - abort in any state: next cycle state=IDLE, all outputs 0, counters cleared. abort outranks eng_done and start in the same cycle.
  - rst asserted mid-operation: immediately forces the reset values.

Test Plan:
- pow3=3, pow5=5, start; engine replies eng_done 4 cycles after each eng_start -> mem_load once; FILL lasts 15 cycles; 3 eng_start with eng_sel=0, eng_len=5; mem_adv high for 15 consecutive cycles; 5 eng_start with eng_sel=1, eng_len=3; exactly one sym_done; busy then 0.
- pow3=27, pow5=25 (N=675) -> FILL lasts 675 cycles and WB lasts 675 cycles with no counter wrap; 27 row blocks and 25 column blocks are issued.
- pow3=0, then pow5=26, then pow3=28 -> cfg_err pulse for each; busy stays 0; no mem_load.
- start pulsed during P1_WAIT and again in the DONE cycle, plus spurious eng_done during FILL -> all ignored; block counts identical to scenario 1.
- abort during WB (cycle 7 of 15) -> next cycle all outputs 0 and busy=0; a new start for pow3=1, pow5=5 completes with 1 row block and 5 column blocks.
- rst asserted mid-P2_WAIT -> outputs 0 asynchronously; after release, IDLE accepts start normally.
